// File: rtl/to_upper_gate.sv
// Byte-wide ASCII lowercase-to-uppercase converter built from AND/OR/NOT gates,
// with a one-cycle registered copy. Optional converted-byte counter: TO_UPPER_CNT_EN.
module to_upper_gate
`ifdef TO_UPPER_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in,
    input  logic             in_vld,
    output logic [7:0]       out,
    output logic [7:0]       out_q,
    output logic             out_vld,
`ifdef TO_UPPER_CNT_EN
    output logic [CNT_W-1:0] cnt,
`endif
    output logic             is_lower
);

    logic lowNonZero;
    logic lowUpTo23;
    logic lowUpTo25;
    logic lowUpTo26;
    logic lowInRange;
    logic upperBits;

    // Low five bits select the letter: non-zero rules out '`', '<= 26' rules out '{'..DEL.
    // 24..26 are 110xx with xx != 11, so only the 2'b11 pattern is excluded there.
    assign lowNonZero = in[4] | in[3] | in[2] | in[1] | in[0];
    assign lowUpTo23  = ~in[4] | (in[4] & ~in[3]);
    assign lowUpTo25  = in[4] & in[3] & ~in[2] & ~(in[1] & in[0]);
    assign lowUpTo26  = lowUpTo23 | lowUpTo25;
    assign lowInRange = lowNonZero & lowUpTo26;

    assign upperBits  = ~in[7] & in[6] & in[5];
    assign is_lower   = upperBits & lowInRange;

    assign out = {in[7:6], in[5] & ~is_lower, in[4:0]};

    logic [7:0] outData_d;
    logic [7:0] outData_q;
    logic       outValid_d;
    logic       outValid_q;

    assign outData_d  = out;
    assign outValid_d = in_vld;

    // Data loads every cycle; downstream logic qualifies it with out_vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outData_q  <= 8'h00;
            outValid_q <= 1'b0;
        end else begin
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
        end
    end

    assign out_q   = outData_q;
    assign out_vld = outValid_q;

`ifdef TO_UPPER_CNT_EN
    logic [CNT_W-1:0] convCount_d;
    logic [CNT_W-1:0] convCount_q;

    always_comb begin
        convCount_d = convCount_q;
        if (in_vld && is_lower) begin
            convCount_d = convCount_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            convCount_q <= '0;
        end else begin
            convCount_q <= convCount_d;
        end
    end

    assign cnt = convCount_q;
`endif

endmodule

// File: tb/tb_to_upper_gate.sv
// Bench for to_upper_gate: combinational sweep plus a scoreboarded registered path.
// Define TO_UPPER_CNT_EN to also exercise the counter (built with CNT_W = 4).
module tb_to_upper_gate;

`ifdef TO_UPPER_CNT_EN
    localparam int CntW = 4;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      in;
    logic            in_vld;
    logic [7:0]      out;
    logic [7:0]      out_q;
    logic            out_vld;
    logic            is_lower;
`ifdef TO_UPPER_CNT_EN
    logic [CntW-1:0] cnt;
`endif

    int         checkCount = 0;
    int         failCount  = 0;
    logic [7:0] expQ[$];

    always #5 clk = ~clk;

`ifdef TO_UPPER_CNT_EN
    to_upper_gate #(.CNT_W(CntW)) dut (
`else
    to_upper_gate dut (
`endif
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .in_vld   (in_vld),
        .out      (out),
        .out_q    (out_q),
        .out_vld  (out_vld),
`ifdef TO_UPPER_CNT_EN
        .cnt      (cnt),
`endif
        .is_lower (is_lower)
    );

    function automatic logic [7:0] refUpper(input logic [7:0] b);
        if (b >= 8'd97 && b <= 8'd122) return b - 8'd32;
        return b;
    endfunction

    function automatic logic refLower(input logic [7:0] b);
        return (b >= 8'd97 && b <= 8'd122);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checkCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Inputs change 1 ns after the rising edge so the next edge captures them.
    task automatic applyStimulus(input logic [7:0] b, input logic v);
        @(posedge clk);
        #1;
        in     = b;
        in_vld = v;
        if (v) expQ.push_back(refUpper(b));
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        in_vld = 1'b0;
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every valid registered byte must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_vld) begin
            if (expQ.size() == 0) checkOutput("spuriousValid", {31'd0, out_vld}, 32'd0);
            else checkOutput("outQ", {24'd0, out_q}, {24'd0, expQ.pop_front()});
        end
    end

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] spotIn[9];
        logic [7:0] spotOut[9];
        logic [7:0] b;

        rst_n  = 1'b0;
        in     = 8'h00;
        in_vld = 1'b0;
        #1;
        checkOutput("resetOutQ", {24'd0, out_q}, 32'd0);
        checkOutput("resetOutVld", {31'd0, out_vld}, 32'd0);
`ifdef TO_UPPER_CNT_EN
        checkOutput("resetCnt", {28'd0, cnt}, 32'd0);
`endif

        for (int i = 0; i < 256; i++) begin
            in = 8'(i);
            #1;
            checkOutput("sweepOut", {24'd0, out}, {24'd0, refUpper(8'(i))});
            checkOutput("sweepIsLower", {31'd0, is_lower}, {31'd0, refLower(8'(i))});
            #4;
        end

        spotIn  = '{8'd40, 8'd72, 8'd97, 8'd122, 8'd123, 8'd109, 8'd235, 8'd127, 8'd65};
        spotOut = '{8'd40, 8'd72, 8'd65, 8'd90,  8'd123, 8'd77,  8'd235, 8'd127, 8'd65};
        for (int i = 0; i < 9; i++) begin
            in = spotIn[i];
            #1;
            checkOutput("spotOut", {24'd0, out}, {24'd0, spotOut[i]});
        end

        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'h6D, 1'b1);
        applyStimulus(8'h20, 1'b0);
        #1;
        checkOutput("regOutQ", {24'd0, out_q}, 32'h4D);
        checkOutput("regOutVld", {31'd0, out_vld}, 32'd1);
        applyStimulus(8'h20, 1'b0);
        #1;
        checkOutput("regVldDrop", {31'd0, out_vld}, 32'd0);

        // Reset between edges while a byte is visible and another is in flight.
        applyStimulus(8'h61, 1'b1);
        applyStimulus(8'h62, 1'b1);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        in_vld = 1'b0;
        expQ.delete();
        #1;
        checkOutput("asyncRstOutQ", {24'd0, out_q}, 32'd0);
        checkOutput("asyncRstOutVld", {31'd0, out_vld}, 32'd0);
        in = 8'h7A;
        #1;
        checkOutput("rstOutTracks", {24'd0, out}, 32'h5A);
        @(posedge clk);
        #1;
        checkOutput("rstHoldOutVld", {31'd0, out_vld}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(8'h5E, 8'h7D));
            applyStimulus(b, 1'($urandom_range(0, 1)));
        end
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);

`ifdef TO_UPPER_CNT_EN
        pulseReset();
        applyStimulus("a", 1'b1);
        applyStimulus("Z", 1'b1);
        applyStimulus("b", 1'b1);
        applyStimulus("{", 1'b1);
        applyStimulus(8'h00, 1'b0);
        @(negedge clk);
        checkOutput("cntStream", {28'd0, cnt}, 32'd2);

        pulseReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'($urandom_range(8'h61, 8'h7A)), 1'b1);
        end
        applyStimulus(8'h00, 1'b0);
        @(negedge clk);
        checkOutput("cntWrap", {28'd0, cnt}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
